ser_frame_rx: RTL

Serial frame receiver that sits directly downstream of the 5-bit universal shift register's serial output. It detects a start bit on the idle-high line and oversamples DIV clocks per bit. It assembles WIDTH data bits, checks parity and stop bit, then presents the word on a valid/ready parallel interface. It is the deserialising end of the block-to-block serial link.

---
 rtl/ser_frame_rx.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ser_frame_rx.sv
// Serial frame receiver: start-bit detection, mid-bit oversampled capture,
// optional parity check, stop-bit check, and a valid/ready word output.
//
// Ports:
//   clk        - clock, all logic on posedge
//   rst        - synchronous active-high reset
//   si         - serial line, idle high; start(0), WIDTH data, [parity], stop(1)
//   out_ready  - consumer accepts out_data when out_valid && out_ready
//   out_data   - received word (registered)
//   out_valid  - out_data holds an unaccepted word
//   parity_err - parity mismatch flag for the word in out_data
//   frame_err  - one-cycle pulse when the stop bit is sampled low
//   overrun    - one-cycle pulse when a completed word is dropped
//   busy       - high in every state except IDLE
module ser_frame_rx #(
    parameter int WIDTH      = 5,
    parameter int DIV        = 4,
    parameter int MSB_FIRST  = 1,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             si,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT
    } state_t;

    localparam int CW = $clog2(DIV);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);
    localparam logic [BW-1:0] LAST    = BW'(WIDTH - 1);
    localparam logic          ODD_BIT = (PARITY_ODD != 0);
    localparam logic          HAS_PAR = (PARITY_EN != 0);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [BW-1:0]    bit_q,   bit_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             err_q,   err_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             valid_q, valid_d;
    logic             perr_q,  perr_d;
    logic             ferr_q,  ferr_d;
    logic             ovr_q,   ovr_d;

    logic             half_tick;
    logic             full_tick;
    logic [WIDTH-1:0] shifted;

    // START samples half a bit in; every later sample is one full bit on.
    assign half_tick = (cnt_q == HALF_M1);
    assign full_tick = (cnt_q == FULL_M1);

    generate
        if (WIDTH == 1) begin : g_w1
            assign shifted = si;
        end else if (MSB_FIRST != 0) begin : g_msb
            assign shifted = {shreg_q[WIDTH-2:0], si};
        end else begin : g_lsb
            assign shifted = {si, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            err_q   <= err_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state and bit-timing logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                err_d = 1'b0;
                if (!si) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (half_tick) begin
                    cnt_d   = '0;
                    // A high line at mid-start is a glitch.
                    state_d = si ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (full_tick) begin
                    cnt_d   = '0;
                    shreg_d = shifted;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LAST) begin
                        bit_d   = '0;
                        state_d = HAS_PAR ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (full_tick) begin
                    cnt_d   = '0;
                    // Odd total of ones is an error for even parity.
                    err_d   = (^shreg_q) ^ si ^ ODD_BIT;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (full_tick) begin
                    cnt_d   = '0;
                    state_d = si ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = '0;
                if (si) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output register next-values and the handshake
    always_comb begin
        valid_d = valid_q & ~out_ready;
        data_d  = data_q;
        perr_d  = perr_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        if ((state_q == S_STOP) && full_tick) begin
            if (si) begin
                // An accept on this edge frees the slot for the new word.
                if (!valid_q || out_ready) begin
                    data_d  = shreg_q;
                    valid_d = 1'b1;
                    perr_d  = HAS_PAR ? err_q : 1'b0;
                end else begin
                    ovr_d = 1'b1;
                end
            end else begin
                ferr_d = 1'b1;
            end
        end
    end

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != S_IDLE);

endmodule
